// File: rtl/fp_mant_div_if.sv
// Handshake and operand/result bundle for the iterative mantissa divider.
// The requester sees master; the divider sees slave. Requests are ignored while busy is high.
interface fp_mant_div_if #(
    parameter int IWID = 26
);
    logic            start;
    logic            flush;
    logic [IWID-1:0] num;
    logic [IWID-1:0] den;
    logic            busy;
    logic            done;
    logic [IWID-1:0] quot;
    logic            sticky;
    logic            err;

    modport master (
        output start, flush, num, den,
        input  busy, done, quot, sticky, err
    );

    modport slave (
        input  start, flush, num, den,
        output busy, done, quot, sticky, err
    );
endinterface

// File: rtl/fp_mant_div.sv
// Restoring mantissa divider: quot = floor(num*2^IWID/den) plus a remainder sticky, IWID edges (IWID/2 with
// FP_MANT_DIV_RADIX4_EN); done pulses one cycle after the last step, and start is ignored while busy.
module fp_mant_div #(
    parameter int IWID = 26
) (
    input  logic         clk,
    input  logic         rst,
    fp_mant_div_if.slave bus
);
`ifdef FP_MANT_DIV_RADIX4_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif
    localparam int CW = $clog2(IWID + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nxt;
    logic [IWID-1:0] den_r;
    logic [IWID:0]   rem, rem_nxt;
    logic [IWID-1:0] q, q_nxt;
    logic [CW-1:0]   cnt;
    logic [IWID-1:0] quot_r;
    logic            sticky_r, err_r;
    logic            accept, bad_ops, last;
    logic [IWID+1:0] s1;
`ifdef FP_MANT_DIV_RADIX4_EN
    logic [IWID+1:0] s2;
`endif

    // One restoring step: returns {quotient_bit, next_remainder}. rem < den keeps r2 within IWID+1 bits.
    function automatic logic [IWID+1:0] rstep(input logic [IWID:0] r, input logic [IWID-1:0] d);
        logic [IWID:0] r2;
        r2 = r << 1;
        if (r2 >= {1'b0, d})
            return {1'b1, r2 - {1'b0, d}};
        else
            return {1'b0, r2};
    endfunction

    assign bad_ops = (bus.den == '0) || (bus.num >= bus.den);
    assign accept  = bus.start && !bus.flush && (state != RUN);
    assign last    = (cnt == CW'(IWID - STEP));

    always_comb begin
        s1      = rstep(rem, den_r);
`ifdef FP_MANT_DIV_RADIX4_EN
        s2      = rstep(s1[IWID:0], den_r);
        rem_nxt = s2[IWID:0];
        q_nxt   = (q << 2) | IWID'({s1[IWID+1], s2[IWID+1]});
`else
        rem_nxt = s1[IWID:0];
        q_nxt   = (q << 1) | IWID'(s1[IWID+1]);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (accept)
                    state_nxt = bad_ops ? DONE : RUN;
                else
                    state_nxt = IDLE;
            end
            RUN: begin
                if (last)
                    state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
        if (bus.flush)
            state_nxt = IDLE;
    end

    // Results only change when an operation completes, so a flushed run leaves the last result visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            den_r    <= '0;
            rem      <= '0;
            q        <= '0;
            cnt      <= '0;
            quot_r   <= '0;
            sticky_r <= 1'b0;
            err_r    <= 1'b0;
        end else if (bus.flush) begin
            cnt <= '0;
        end else if (accept) begin
            den_r <= bus.den;
            rem   <= {1'b0, bus.num};
            q     <= '0;
            cnt   <= '0;
            if (bad_ops) begin
                quot_r   <= '1;
                sticky_r <= 1'b1;
                err_r    <= 1'b1;
            end
        end else if (state == RUN) begin
            rem <= rem_nxt;
            q   <= q_nxt;
            cnt <= cnt + CW'(STEP);
            if (last) begin
                quot_r   <= q_nxt;
                sticky_r <= |rem_nxt;
                err_r    <= 1'b0;
            end
        end
    end

    assign bus.busy   = (state == RUN);
    assign bus.done   = (state == DONE);
    assign bus.quot   = quot_r;
    assign bus.sticky = sticky_r;
    assign bus.err    = err_r;
endmodule
